// File: rtl/uart_cmd_pkg.sv
// Shared constants, state/response encodings and
// hex helpers for the UART command executor.
package uart_cmd_pkg;

  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_SP = 8'h20;
  localparam logic [7:0] CH_R  = 8'h72;
  localparam logic [7:0] CH_W  = 8'h77;
  localparam logic [7:0] CH_O  = 8'h4F;
  localparam logic [7:0] CH_K  = 8'h4B;
  localparam logic [7:0] CH_E  = 8'h45;
  localparam logic [7:0] CH_RU = 8'h52;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_PARSE,
    S_ERRSKIP,
    S_EXEC,
    S_WRESP,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    RSP_NL,
    RSP_OK,
    RSP_VAL,
    RSP_ERR
  } rsp_t;

  typedef struct packed {
    logic       ok;
    logic [3:0] nib;
  } hex_t;

  function automatic hex_t hex2nib(
    input logic [7:0] c
  );
    hex_t r;
    r.ok  = 1'b1;
    r.nib = 4'h0;
    unique case (1'b1)
      (c >= 8'h30 && c <= 8'h39):
        r.nib = c[3:0];
      (c >= 8'h41 && c <= 8'h46),
      (c >= 8'h61 && c <= 8'h66):
        r.nib = c[3:0] + 4'd9;
      default:
        r.ok = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] nib2hex(
    input logic [3:0] n
  );
    if (n < 4'd10)
      return {4'h3, n};
    return 8'h37 + {4'h0, n};
  endfunction

endpackage

// File: rtl/uart_cmd_executor_resp.sv
// Streams one response template into the
// TX area of the shared RAM, one byte per cycle.
module uart_resp_writer
  import uart_cmd_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int AW         = 9,
  parameter int TXSTR_BASE = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  rsp_t             code,
  input  logic [7:0]       val,
  output logic [AW-1:0]    addr,
  output logic [WIDTH-1:0] din,
  output logic             we,
  output logic             last,
  output logic [AW-1:0]    len
);

  rsp_t             code_q, code_d;
  logic [7:0]       val_q, val_d;
  logic [2:0]       j_q, j_d;
  logic             act_q, act_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [WIDTH-1:0] din_q, din_d;
  logic             we_q, we_d;

  function automatic logic [2:0] rlen(
    input rsp_t c
  );
    case (c)
      RSP_NL:  return 3'd2;
      RSP_ERR: return 3'd5;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [7:0] tmpl(
    input rsp_t       c,
    input logic [7:0] v,
    input logic [2:0] j
  );
    logic [7:0] b;
    b = CH_LF;
    case (c)
      RSP_NL:
        if (j == 3'd0) b = CH_CR;
      RSP_OK:
        case (j)
          3'd0: b = CH_O;
          3'd1: b = CH_K;
          3'd2: b = CH_CR;
          default: b = CH_LF;
        endcase
      RSP_VAL:
        case (j)
          3'd0: b = nib2hex(v[7:4]);
          3'd1: b = nib2hex(v[3:0]);
          3'd2: b = CH_CR;
          default: b = CH_LF;
        endcase
      default:
        case (j)
          3'd0: b = CH_E;
          3'd1, 3'd2: b = CH_RU;
          3'd3: b = CH_CR;
          default: b = CH_LF;
        endcase
    endcase
    return b;
  endfunction

  assign last = act_q && (j_q == rlen(code_q) - 3'd1);
  assign len  = AW'(rlen(code_q));
  assign addr = addr_q;
  assign din  = din_q;
  assign we   = we_q;

  // latch template on start, then emit byte j each cycle
  always_comb begin
    code_d = code_q;
    val_d  = val_q;
    j_d    = j_q;
    act_d  = act_q;
    addr_d = addr_q;
    din_d  = din_q;
    we_d   = 1'b0;
    if (start) begin
      code_d = code;
      val_d  = val;
      j_d    = 3'd0;
      act_d  = 1'b1;
    end else if (act_q) begin
      addr_d = AW'(TXSTR_BASE) + AW'(j_q);
      din_d  = WIDTH'(tmpl(code_q, val_q, j_q));
      we_d   = 1'b1;
      j_d    = j_q + 3'd1;
      if (last) act_d = 1'b0;
    end
  end

  // writer state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q <= RSP_NL;
      val_q  <= '0;
      j_q    <= '0;
      act_q  <= 1'b0;
      addr_q <= '0;
      din_q  <= '0;
      we_q   <= 1'b0;
    end else begin
      code_q <= code_d;
      val_q  <= val_d;
      j_q    <= j_d;
      act_q  <= act_d;
      addr_q <= addr_d;
      din_q  <= din_d;
      we_q   <= we_d;
    end
  end

endmodule

// File: rtl/uart_cmd_executor.sv
// Reads a command line from RAM, runs r/w register
// accesses and writes an ASCII reply back to RAM.
module uart_cmd_executor
  import uart_cmd_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int LEN        = 256,
  parameter int RXSTR_BASE = 0,
  parameter int TXSTR_BASE = 128,
  parameter int NREG       = 16,
  parameter int AW         = $clog2(LEN-1) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  input  logic [AW-1:0]     cmd_len,
  output logic              msg_valid,
  output logic [AW-1:0]     msg_len,
  output logic              busy,
  output logic [AW-1:0]     addr,
  output logic [WIDTH-1:0]  din,
  input  logic [WIDTH-1:0]  dout,
  output logic              we,
  output logic [8*NREG-1:0] reg_out
);

  state_t        state_q;
  logic          busy_q;
  logic          msg_valid_q;
  logic [AW-1:0] msg_len_q;
  logic [AW-1:0] rd_addr_q;
  logic [AW-1:0] idx_q;
  logic [AW-1:0] len_q;
  logic [2:0]    pos_q;
  logic          op_w_q;
  logic          err_q;
  logic [3:0]    ridx_q;
  logic [7:0]    data_q;
  logic [7:0]    regs_q [NREG];

  logic [7:0]    p_byte;
  logic [7:0]    p_lc;
  hex_t          p_hex;
  logic          p_term;
  logic          p_bad;
  logic          p_end;
  rsp_t          code;
  logic [AW-1:0] w_addr;
  logic [AW-1:0] w_len;
  logic          w_we;
  logic          w_last;
  logic          w_own;

  assign msg_valid = msg_valid_q;
  assign msg_len   = msg_len_q;
  assign busy      = busy_q;
  assign w_own     = (state_q == S_WRESP)
                  || (state_q == S_DONE);
  assign addr      = w_own ? w_addr : rd_addr_q;
  assign we        = w_we;
  assign p_end     = (idx_q + AW'(1)) == len_q;

  // flatten register file for the port
  always_comb begin
    reg_out = '0;
    for (int k = 0; k < NREG; k++)
      reg_out[8*k +: 8] = regs_q[k];
  end

  // classify the current byte by its position
  always_comb begin
    p_byte = dout[7:0];
    p_lc   = p_byte | 8'h20;
    p_hex  = hex2nib(p_byte);
    p_term = (p_byte == CH_CR)
          || (p_byte == CH_LF);
    case (pos_q)
      3'd0: p_bad = !(p_lc == CH_R
                   || p_lc == CH_W);
      3'd1: p_bad = p_byte != CH_SP;
      3'd2: p_bad = !p_hex.ok
                 || int'(p_hex.nib) >= NREG;
      3'd3: p_bad = !op_w_q
                 || p_byte != CH_SP;
      3'd4,
      3'd5: p_bad = !p_hex.ok;
      default: p_bad = 1'b1;
    endcase
  end

  // pick the reply from the final parse state
  always_comb begin
    code = RSP_ERR;
    if (len_q <= AW'(1))
      code = RSP_NL;
    else if (err_q)
      code = RSP_ERR;
    else if (pos_q == 3'd0)
      code = RSP_NL;
    else if (!op_w_q && pos_q == 3'd3)
      code = RSP_VAL;
    else if (op_w_q && pos_q == 3'd6)
      code = RSP_OK;
  end

  uart_resp_writer #(
    .WIDTH      (WIDTH),
    .AW         (AW),
    .TXSTR_BASE (TXSTR_BASE)
  ) u_resp (
    .clk   (clk),
    .rst_n (rst_n),
    .start (state_q == S_EXEC),
    .code  (code),
    .val   (regs_q[ridx_q]),
    .addr  (w_addr),
    .din   (din),
    .we    (w_we),
    .last  (w_last),
    .len   (w_len)
  );

  // command fetch / parse / execute sequencer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      msg_valid_q <= 1'b0;
      msg_len_q   <= '0;
      rd_addr_q   <= '0;
      idx_q       <= '0;
      len_q       <= '0;
      pos_q       <= '0;
      op_w_q      <= 1'b0;
      err_q       <= 1'b0;
      ridx_q      <= '0;
      data_q      <= '0;
      for (int k = 0; k < NREG; k++)
        regs_q[k] <= '0;
    end else begin
      msg_valid_q <= 1'b0;
      case (state_q)
        S_IDLE:
          if (cmd_valid) begin
            len_q   <= cmd_len;
            idx_q   <= '0;
            pos_q   <= '0;
            op_w_q  <= 1'b0;
            err_q   <= 1'b0;
            ridx_q  <= '0;
            data_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= S_FETCH;
          end
        S_FETCH: begin
          rd_addr_q <= AW'(RXSTR_BASE) + idx_q;
          state_q   <= S_WAIT;
        end
        S_WAIT:
          state_q <= S_PARSE;
        S_PARSE:
          if (p_term) begin
            state_q <= S_EXEC;
          end else begin
            case (pos_q)
              3'd0: op_w_q <= p_lc == CH_W;
              3'd2: ridx_q <= p_hex.nib;
              3'd4: data_q[7:4] <= p_hex.nib;
              3'd5: data_q[3:0] <= p_hex.nib;
              default: ;
            endcase
            pos_q <= pos_q + 3'd1;
            if (p_bad) err_q <= 1'b1;
            if (p_end)
              state_q <= S_EXEC;
            else if (p_bad)
              state_q <= S_ERRSKIP;
            else begin
              idx_q   <= idx_q + AW'(1);
              state_q <= S_FETCH;
            end
          end
        S_ERRSKIP: begin
          err_q   <= 1'b1;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          if (code == RSP_OK)
            regs_q[ridx_q] <= data_q;
          state_q <= S_WRESP;
        end
        S_WRESP:
          if (w_last) state_q <= S_DONE;
        S_DONE: begin
          msg_len_q   <= w_len;
          msg_valid_q <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
        default:
          state_q <= S_IDLE;
      endcase
    end
  end

endmodule
